// File: rtl/dlatch_response_checker.sv
// Clocked monitor for D-latch devices: tracks the expected latch value
// and checks Q/Q_bar after a bounded settle delay.
module dlatch_response_checker #(
    parameter int MAX_DELAY = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic             fail,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cmp_count
);

    localparam int DLY_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        SETTLE  = 2'd1,
        STABLE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [DLY_W-1:0] r_cnt;
    logic [DLY_W-1:0] w_cnt_n;
    logic             r_exp_q;
    logic             w_exp_q_n;
    logic             r_exp_valid;
    logic             w_exp_valid_n;
    logic             r_err;
    logic             w_err_n;
    logic             r_fail;
    logic             w_fail_n;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] w_err_count_n;
    logic [CNT_W-1:0] r_cmp_count;
    logic [CNT_W-1:0] w_cmp_count_n;
    logic             w_upd;
    logic             w_cmp;
    logic             w_pass;

    assign w_upd  = en && ((r_state == UNKNOWN) || (d != r_exp_q));
    assign w_pass = (q == r_exp_q) && (q_bar == ~q);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_exp_q_n     = r_exp_q;
        w_exp_valid_n = r_exp_valid;
        w_err_n       = 1'b0;
        w_fail_n      = r_fail;
        w_err_count_n = r_err_count;
        w_cmp_count_n = r_cmp_count;
        w_cmp         = 1'b0;
        if (w_upd) begin
            w_exp_q_n     = d;
            w_exp_valid_n = 1'b1;
            w_cnt_n       = DLY_W'(MAX_DELAY);
            w_state_n     = SETTLE;
        end else begin
            unique case (r_state)
                SETTLE: begin
                    if (r_cnt != '0) begin
                        w_cnt_n = r_cnt - DLY_W'(1);
                    end else begin
                        w_cmp     = 1'b1;
                        w_state_n = STABLE;
                    end
                end
                STABLE:  w_cmp = 1'b1;
                default: w_state_n = r_state;
            endcase
        end
        if (w_cmp) begin
            if (r_cmp_count != '1) begin
                w_cmp_count_n = r_cmp_count + CNT_W'(1);
            end
            // Written as pass/else so an unknown q counts as a failure.
            if (w_pass) begin
                w_err_n = 1'b0;
            end else begin
                w_err_n  = 1'b1;
                w_fail_n = 1'b1;
                if (r_err_count != '1) begin
                    w_err_count_n = r_err_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= UNKNOWN;
            r_cnt       <= '0;
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_fail      <= 1'b0;
            r_err_count <= '0;
            r_cmp_count <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_exp_q     <= w_exp_q_n;
            r_exp_valid <= w_exp_valid_n;
            r_err       <= w_err_n;
            r_fail      <= w_fail_n;
            r_err_count <= w_err_count_n;
            r_cmp_count <= w_cmp_count_n;
        end
    end

    assign exp_q     = r_exp_q;
    assign exp_valid = r_exp_valid;
    assign err       = r_err;
    assign fail      = r_fail;
    assign err_count = r_err_count;
    assign cmp_count = r_cmp_count;

endmodule

// File: tb/tb_dlatch_response_checker.sv
// Randomised scoreboard bench for dlatch_response_checker against an
// age-based reference model of the expected latch behaviour.
module tb_dlatch_response_checker;

    localparam int MAX_DELAY = 3;
    localparam int CNT_W     = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d = 1'b0;
    logic             en = 1'b0;
    logic             q = 1'b0;
    logic             q_bar = 1'b1;
    logic             exp_q;
    logic             exp_valid;
    logic             err;
    logic             fail;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] cmp_count;

    typedef struct packed {
        logic             eq;
        logic             ev;
        logic             er;
        logic             fl;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] cc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;

    // reference model: value, validity, edges since last load
    logic m_exp = 1'b0;
    logic m_valid = 1'b0;
    int   m_age = 0;
    logic m_fail = 1'b0;
    int   m_errc = 0;
    int   m_cmpc = 0;

    dlatch_response_checker #(
        .MAX_DELAY(MAX_DELAY),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d(d),
        .en(en),
        .q(q),
        .q_bar(q_bar),
        .exp_q(exp_q),
        .exp_valid(exp_valid),
        .err(err),
        .fail(fail),
        .err_count(err_count),
        .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic dd, input logic ee,
                        input logic qq, input logic qqb);
        exp_t e;
        logic bad;
        @(negedge clk);
        rst = r; d = dd; en = ee; q = qq; q_bar = qqb;
        bad = 1'b0;
        if (r) begin
            m_exp = 1'b0; m_valid = 1'b0; m_age = 0;
            m_fail = 1'b0; m_errc = 0; m_cmpc = 0;
        end else if (ee && (!m_valid || dd != m_exp)) begin
            m_exp = dd; m_valid = 1'b1; m_age = 0;
        end else if (m_valid) begin
            if (m_age < 1000) m_age++;
            if (m_age >= MAX_DELAY + 1) begin
                if (m_cmpc < CMAX) m_cmpc++;
                if (!(qq == m_exp && qqb == !qq)) begin
                    bad = 1'b1;
                    m_fail = 1'b1;
                    if (m_errc < CMAX) m_errc++;
                end
            end
        end
        e.eq = m_exp; e.ev = m_valid; e.er = bad; e.fl = m_fail;
        e.ec = CNT_W'(m_errc); e.cc = CNT_W'(m_cmpc);
        sb.push_back(e);
    endtask

    // monitor: outputs are presented every cycle, checked after the edge
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a.eq = exp_q; a.ev = exp_valid; a.er = err; a.fl = fail;
                a.ec = err_count; a.cc = cmp_count;
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t got q=%b v=%b err=%b fail=%b ec=%0d cc=%0d want q=%b v=%b err=%b fail=%b ec=%0d cc=%0d",
                             $time, a.eq, a.ev, a.er, a.fl, a.ec, a.cc,
                             e.eq, e.ev, e.er, e.fl, e.ec, e.cc);
                end
            end
        end
    end

    initial begin
        logic rq;
        logic rd;
        logic re;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom), 0, 1'($urandom), 1'($urandom));
        // clean load, q follows from E2
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0);
        // late q: rises at E5
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0);
        // hold with en low while d toggles
        for (int i = 0; i < 12; i++) step(0, 1'((i / 2) % 2), 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 0);
        // d changes on the falling-gate edge
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        // saturation
        for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1);
        // reset during SETTLE
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        // random phase, q mostly tracks the model
        for (int i = 0; i < 250; i++) begin
            rd = 1'($urandom);
            re = ($urandom_range(0, 3) == 0);
            rq = m_exp ^ ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 99) == 0), rd, re, rq,
                 ($urandom_range(0, 15) == 0) ? rq : !rq);
        end
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d left want 0", sb.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout got no end want end");
            n_errors++;
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/dlatch_response_checker.md
Name: dlatch_response_checker

Overview:
- Synchronous hardware monitor for the clocked D-latch blocks: the consuming end of the latch stimulus interface.
- Observes the latch's data input, gate, Q and Q_bar on a fast system clock.
- Keeps a reference model of the expected latch state and checks that the device follows D while its gate is high within a bounded delay, and holds while the gate is low.
- Reports per-sample errors and saturating error/comparison counters so latch variants (with and without gate delays) self-check in simulation or on a board.

Parameters:
- MAX_DELAY, 3: number of clk cycles Q may lag the sampled D/gate change before it is checked.
- CNT_W, 8: width of the err_count and cmp_count counters.
- DLY_W, $clog2(MAX_DELAY+1) (min 1): derived width of the settle counter; not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  1  latch data input, as driven to the device under check.
- en  input  1  latch gate/clock, as driven to the device under check.
- q  input  1  device Q output.
- q_bar  input  1  device Q_bar output.
- exp_q  output  1  reference-model latch value.
- exp_valid  output  1  reference model has been loaded at least once since reset.
- err  output  1  one-cycle pulse: the comparison at the previous edge failed.
- fail  output  1  sticky: any error since reset.
- err_count  output  CNT_W  saturating count of failed comparisons.
- cmp_count  output  CNT_W  saturating count of comparisons performed.

Behaviour:
- Inputs are already synchronous to clk; there is no synchronizer. Each input is sampled once per rising edge. All outputs are registered.
- Reset (rst=1 at an edge):
  - state=UNKNOWN, exp_q=0, exp_valid=0, err=0, fail=0, err_count=0, cmp_count=0, settle counter=0.
  - Takes priority over all other events. Reset mid-SETTLE or mid-STABLE discards all history.
- Update event: an edge where en=1 and (state=UNKNOWN or d!=exp_q). On this edge:
  - exp_q<=d, exp_valid<=1, settle counter<=MAX_DELAY, state<=SETTLE.
  - The edge on which this happens is called E0.
- Edges where en=0 never modify exp_q. A d change sampled together with en=0, including the edge where en falls, is ignored.
- State UNKNOWN: no comparisons. q and q_bar may be X/0/1. Leaves only via an update event.
- State SETTLE:
  - A new update event restarts SETTLE (reload the counter, no comparison).
  - Otherwise, if counter!=0: decrement, no comparison.
  - If counter==0: perform a comparison and go to STABLE.
  - Net effect: the first comparison after E0 occurs at edge E(MAX_DELAY+1).
- State STABLE:
  - An update event goes to SETTLE with no comparison on that edge.
  - Otherwise, perform a comparison every edge.
- Comparison:
  - Passes iff q==exp_q and q_bar==~q. X/Z on q or q_bar counts as a failure.
  - cmp_count increments, saturating at 2^CW-1.
  - On failure: err<=1 for exactly one cycle, fail<=1 (sticky until rst), err_count increments, saturating at 2^CW-1.
  - err<=0 on every edge without a failed comparison.
- Saturation: each counter holds at its maximum value and never wraps. Comparisons continue after saturation.

Test Plan:
- Reset, then en=0 for 20 cycles while q/q_bar toggle or sit at X -> exp_valid=0, cmp_count=0, err never asserted, fail=0.
- MAX_DELAY=3: en=1, d=1 at E0; q=1, q_bar=0 from E2 on -> exp_valid=1 and exp_q=1 after E0; first comparison at E4 passes; cmp_count=1 after E4 and increments each later edge; err_count=0.
- Same as the previous case, but q rises only at E5 -> comparison at E4 fails; err high for the one cycle after E4; err_count=1, fail=1; later comparisons pass and fail stays 1.
- STABLE with exp_q=1, then en=0 and d toggles every 2 cycles while q holds 1 -> no errors and exp_q stays 1. Then force q=0 for 2 cycles with en=0 -> err_count +2.
- q_bar forced equal to q for one cycle in STABLE -> exactly one err pulse, err_count +1. Also: d changes on the same edge en falls -> exp_q unchanged and no SETTLE entry.
- CNT_W=8: hold q wrong for 300 STABLE cycles -> err_count=255 and cmp_count saturates at 255. Then assert rst during a SETTLE period -> all outputs 0 the next cycle, state UNKNOWN.
